// File: rtl/seg_mask_pkg.sv
// seg_mask_pkg: shared constants and helpers for the URNG segment masker.
// Bit reversal and mask decode are reused by the ICDF address builder.
package seg_mask_pkg;

  localparam int DATA_W_DEF    = 15;
  localparam int ZPOS_W_DEF    = 6;
  localparam int ZPOS_BASE_DEF = 46;
  localparam int MAX_W         = 64;

  typedef logic [MAX_W-1:0] wide_t;

  typedef struct packed {
    wide_t mask;
    logic  hit;
  } mask_dec_t;

  // Reverse the low w bits of x; bits above w come back zero.
  function automatic wide_t bitrev(input wide_t x, input int w);
    wide_t r;
    wide_t t;
    r = '0;
    t = x;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) begin
        r = {r[MAX_W-2:0], t[0]};
        t = t >> 1;
      end
    end
    return r;
  endfunction

  // All-ones mask with bit idx cleared when idx selects a bit of a
  // w-bit segment; otherwise all-ones and no hit.
  function automatic mask_dec_t mask_dec(input logic [31:0] idx,
                                         input int w);
    mask_dec_t m;
    m.hit  = (idx < 32'(w));
    m.mask = '1;
    if (m.hit) m.mask = ~(wide_t'(1) << idx);
    return m;
  endfunction

endpackage

// File: rtl/seg_mask_lane.sv
// seg_mask_lane: combinational reverse + mask decode for one lane.
// Ports: mode_rev_i, seg_i, zpos_i in; d_o, mask_o, hit_o out.
module seg_mask_lane
  import seg_mask_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ZPOS_W    = ZPOS_W_DEF,
  parameter int ZPOS_BASE = ZPOS_BASE_DEF
)(
  input  logic              mode_rev_i,
  input  logic [DATA_W-1:0] seg_i,
  input  logic [ZPOS_W-1:0] zpos_i,
  output logic [DATA_W-1:0] d_o,
  output logic [DATA_W-1:0] mask_o,
  output logic              hit_o
);

  localparam logic [ZPOS_W:0] BASE_C = ZPOS_BASE[ZPOS_W:0];

  // One extra bit so positions below the base land far out of range
  // instead of wrapping back into it.
  logic [ZPOS_W:0] idx;
  wide_t           rev;
  mask_dec_t       dec;
  logic            unused_hi;

  assign idx    = {1'b0, zpos_i} - BASE_C;
  assign rev    = bitrev(wide_t'(seg_i), DATA_W);
  assign dec    = mask_dec(32'(idx), DATA_W);
  assign d_o    = mode_rev_i ? rev[DATA_W-1:0] : seg_i;
  assign mask_o = dec.mask[DATA_W-1:0];
  assign hit_o  = dec.hit;

  assign unused_hi = ^{rev[MAX_W-1:DATA_W],
                       dec.mask[MAX_W-1:DATA_W]};

endmodule

// File: rtl/seg_mask_pipe.sv
// seg_mask_pipe: NCH-lane 2-stage valid/ready URNG segment masker.
// Ports: clk, rst (async low), en, mode_rev, in_valid/in_ready,
//   zero_pos, urng_seg, out_valid/out_ready, masked_data, mask_hit.
// SEG_MASK_STATS_EN adds stats_clr in and mask_cnt out (hit counter).
module seg_mask_pipe
  import seg_mask_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ZPOS_W    = ZPOS_W_DEF,
  parameter int ZPOS_BASE = ZPOS_BASE_DEF,
  parameter int NCH       = 1,
  parameter int CNT_W     = 16
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode_rev,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NCH*ZPOS_W-1:0] zero_pos,
  input  logic [NCH*DATA_W-1:0] urng_seg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NCH*DATA_W-1:0] masked_data,
  output logic [NCH-1:0]        mask_hit
`ifdef SEG_MASK_STATS_EN
  ,
  input  logic                  stats_clr,
  output logic [CNT_W-1:0]      mask_cnt
`endif
);

  localparam int DW = NCH*DATA_W;

  logic [DW-1:0]  ln_d;
  logic [DW-1:0]  ln_mask;
  logic [NCH-1:0] ln_hit;

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    seg_mask_lane #(
      .DATA_W    (DATA_W),
      .ZPOS_W    (ZPOS_W),
      .ZPOS_BASE (ZPOS_BASE)
    ) u_lane (
      .mode_rev_i (mode_rev),
      .seg_i      (urng_seg[g*DATA_W +: DATA_W]),
      .zpos_i     (zero_pos[g*ZPOS_W +: ZPOS_W]),
      .d_o        (ln_d[g*DATA_W +: DATA_W]),
      .mask_o     (ln_mask[g*DATA_W +: DATA_W]),
      .hit_o      (ln_hit[g])
    );
  end

  logic           s1_vld_q, s1_vld_d;
  logic [DW-1:0]  s1_d_q, s1_d_d;
  logic [DW-1:0]  s1_mask_q, s1_mask_d;
  logic [NCH-1:0] s1_hit_q, s1_hit_d;
  logic           s2_vld_q, s2_vld_d;
  logic [DW-1:0]  s2_data_q, s2_data_d;
  logic [NCH-1:0] s2_hit_q, s2_hit_d;
  logic           adv1, adv2;

  assign adv2     = ~s2_vld_q | out_ready;
  assign adv1     = ~s1_vld_q | adv2;
  assign in_ready = adv1 & en;

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_d_d    = s1_d_q;
    s1_mask_d = s1_mask_q;
    s1_hit_d  = s1_hit_q;
    s2_vld_d  = s2_vld_q;
    s2_data_d = s2_data_q;
    s2_hit_d  = s2_hit_q;
    if (!en) begin
      // Flush: in-flight beats are dropped, not delivered.
      s1_vld_d  = 1'b0;
      s2_vld_d  = 1'b0;
      s2_data_d = '0;
      s2_hit_d  = '0;
    end else begin
      if (adv1) begin
        s1_vld_d = in_valid;
        if (in_valid) begin
          s1_d_d    = ln_d;
          s1_mask_d = ln_mask;
          s1_hit_d  = ln_hit;
        end
      end
      if (adv2) begin
        s2_vld_d = s1_vld_q;
        // On a bubble the data registers keep their last value.
        if (s1_vld_q) begin
          s2_data_d = s1_d_q & s1_mask_q;
          s2_hit_d  = s1_hit_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld_q  <= 1'b0;
      s1_d_q    <= '0;
      s1_mask_q <= '0;
      s1_hit_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_data_q <= '0;
      s2_hit_q  <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_d_q    <= s1_d_d;
      s1_mask_q <= s1_mask_d;
      s1_hit_q  <= s1_hit_d;
      s2_vld_q  <= s2_vld_d;
      s2_data_q <= s2_data_d;
      s2_hit_q  <= s2_hit_d;
    end
  end

  assign out_valid   = s2_vld_q;
  assign masked_data = s2_data_q;
  assign mask_hit    = s2_hit_q;

`ifdef SEG_MASK_STATS_EN
  localparam int PC_W = $clog2(NCH+1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  pop;
  logic [CNT_W:0]   sum;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NCH; i++) begin
      pop = pop + PC_W'(s2_hit_q[i]);
    end
    sum   = {1'b0, cnt_q} + (CNT_W+1)'(pop);
    cnt_d = cnt_q;
    if (stats_clr) begin
      cnt_d = '0;
    end else if (s2_vld_q & out_ready) begin
      cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign mask_cnt = cnt_q;
`else
  localparam int CNT_W_UNUSED = CNT_W;
`endif

endmodule

// File: tb/tb_seg_mask_pipe.sv
// tb_seg_mask_pipe: directed table + sequence checks for seg_mask_pipe.
// Covers decode, latency, stall, flush, reset and a 4-lane instance.
module tb_seg_mask_pipe;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        a_en, a_rev, a_iv, a_ir, a_ov, a_ordy;
  logic [5:0]  a_zp;
  logic [14:0] a_seg, a_md;
  logic [0:0]  a_mh;

  logic        b_en, b_rev, b_iv, b_ir, b_ov, b_ordy;
  logic [23:0] b_zp;
  logic [59:0] b_seg, b_md;
  logic [3:0]  b_mh;

`ifdef SEG_MASK_STATS_EN
  logic        a_clr, b_clr;
  logic [15:0] a_cnt;
  logic [3:0]  b_cnt;
`endif

  seg_mask_pipe u_a (
    .clk         (clk),
    .rst         (rst),
    .en          (a_en),
    .mode_rev    (a_rev),
    .in_valid    (a_iv),
    .in_ready    (a_ir),
    .zero_pos    (a_zp),
    .urng_seg    (a_seg),
    .out_valid   (a_ov),
    .out_ready   (a_ordy),
    .masked_data (a_md),
    .mask_hit    (a_mh)
`ifdef SEG_MASK_STATS_EN
    ,
    .stats_clr   (a_clr),
    .mask_cnt    (a_cnt)
`endif
  );

  seg_mask_pipe #(.NCH(4), .CNT_W(4)) u_b (
    .clk         (clk),
    .rst         (rst),
    .en          (b_en),
    .mode_rev    (b_rev),
    .in_valid    (b_iv),
    .in_ready    (b_ir),
    .zero_pos    (b_zp),
    .urng_seg    (b_seg),
    .out_valid   (b_ov),
    .out_ready   (b_ordy),
    .masked_data (b_md),
    .mask_hit    (b_mh)
`ifdef SEG_MASK_STATS_EN
    ,
    .stats_clr   (b_clr),
    .mask_cnt    (b_cnt)
`endif
  );

  typedef struct {
    logic        rev;
    logic [14:0] seg;
    logic [5:0]  zp;
    logic [14:0] md;
    logic        hit;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t        vt[8];
  logic [14:0] beats[4];
  int          snd, rcv;

  initial begin
    vt[0] = '{1'b1, 15'h0001, 6'd60, 15'h0000, 1'b1};
    vt[1] = '{1'b1, 15'h0001, 6'd61, 15'h4000, 1'b0};
    vt[2] = '{1'b0, 15'h7FFF, 6'd46, 15'h7FFE, 1'b1};
    vt[3] = '{1'b0, 15'h7FFF, 6'd45, 15'h7FFF, 1'b0};
    vt[4] = '{1'b0, 15'h7FFF, 6'd0,  15'h7FFF, 1'b0};
    vt[5] = '{1'b0, 15'h7FFF, 6'd63, 15'h7FFF, 1'b0};
    vt[6] = '{1'b0, 15'h1234, 6'd50, 15'h1224, 1'b1};
    vt[7] = '{1'b1, 15'h0003, 6'd59, 15'h4000, 1'b1};
    beats[0] = 15'h0011;
    beats[1] = 15'h0022;
    beats[2] = 15'h0033;
    beats[3] = 15'h0044;

    a_en = 1'b1; a_rev = 1'b0; a_iv = 1'b0; a_ordy = 1'b1;
    a_zp = '0; a_seg = '0;
    b_en = 1'b1; b_rev = 1'b0; b_iv = 1'b0; b_ordy = 1'b1;
    b_zp = '0; b_seg = '0;
`ifdef SEG_MASK_STATS_EN
    a_clr = 1'b0; b_clr = 1'b0;
`endif

    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("rst_ov", 64'(a_ov), 64'd0);
    chk("rst_md", 64'(a_md), 64'd0);
    chk("rst_mh", 64'(a_mh), 64'd0);
    chk("rst_ir", 64'(a_ir), 64'd1);
    chk("rst_b_md", 64'(b_md), 64'd0);

    // Decode table: accept, check latency, result, then bubble.
    for (int i = 0; i < 8; i++) begin
      a_rev = vt[i].rev; a_seg = vt[i].seg; a_zp = vt[i].zp;
      a_iv = 1'b1;
      tick();
      a_iv = 1'b0;
      chk($sformatf("v%0d_lat1", i), 64'(a_ov), 64'd0);
      tick();
      chk($sformatf("v%0d_ov", i), 64'(a_ov), 64'd1);
      chk($sformatf("v%0d_md", i), 64'(a_md), 64'(vt[i].md));
      chk($sformatf("v%0d_mh", i), 64'(a_mh), 64'(vt[i].hit));
      tick();
      chk($sformatf("v%0d_bub", i), 64'(a_ov), 64'd0);
      chk($sformatf("v%0d_keep", i), 64'(a_md), 64'(vt[i].md));
    end

    // Backpressure: pass-through beats (zp=0, no reverse).
    a_rev = 1'b0; a_zp = 6'd0; a_ordy = 1'b0;
    a_iv = 1'b1; a_seg = beats[0];
    #1;
    chk("bp_ir0", 64'(a_ir), 64'd1);
    tick();
    a_seg = beats[1];
    chk("bp_ir1", 64'(a_ir), 64'd1);
    tick();
    a_seg = beats[2];
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_stall_ir%0d", k), 64'(a_ir), 64'd0);
      chk($sformatf("bp_stall_ov%0d", k), 64'(a_ov), 64'd1);
      chk($sformatf("bp_stall_md%0d", k), 64'(a_md),
          64'(beats[0]));
      if (k < 2) tick();
    end
    a_ordy = 1'b1;
    snd = 2;
    rcv = 0;
    for (int c = 0; c < 30 && rcv < 4; c++) begin
      #1;
      if (a_ov && a_ordy) begin
        chk($sformatf("bp_rx%0d", rcv), 64'(a_md), 64'(beats[rcv]));
        rcv++;
      end
      if (a_iv && a_ir) snd++;
      tick();
      a_iv = (snd < 4);
      a_seg = beats[snd < 4 ? snd : 3];
    end
    chk("bp_rcv", 64'(rcv), 64'd4);
    chk("bp_snd", 64'(snd), 64'd4);
    chk("bp_nodup", 64'(a_ov), 64'd0);

    // Flush with two beats in flight.
    a_iv = 1'b1; a_seg = beats[0];
    tick();
    a_seg = beats[1];
    tick();
    a_iv = 1'b0; a_en = 1'b0;
    #1;
    chk("fl_ir_now", 64'(a_ir), 64'd0);
    tick();
    chk("fl_ov", 64'(a_ov), 64'd0);
    chk("fl_md", 64'(a_md), 64'd0);
    chk("fl_ir", 64'(a_ir), 64'd0);
    tick();
    chk("fl_drop", 64'(a_ov), 64'd0);
    a_en = 1'b1; a_iv = 1'b1;
    a_seg = 15'h7FFF; a_zp = 6'd46;
    tick();
    a_iv = 1'b0;
    chk("fl_lat1", 64'(a_ov), 64'd0);
    tick();
    chk("fl_new_ov", 64'(a_ov), 64'd1);
    chk("fl_new_md", 64'(a_md), 64'h7FFE);
    chk("fl_new_mh", 64'(a_mh), 64'd1);
    tick();

    // Asynchronous reset mid-operation.
    a_iv = 1'b1; a_seg = 15'h0ABC; a_zp = 6'd0;
    tick();
    tick();
    a_iv = 1'b0;
    chk("rm_pre_ov", 64'(a_ov), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("rm_ov", 64'(a_ov), 64'd0);
    chk("rm_md", 64'(a_md), 64'd0);
    rst = 1'b1;
    tick();
    tick();
    chk("rm_nosurv", 64'(a_ov), 64'd0);

    // Four lanes, lane 0 in the low bits.
    b_rev = 1'b1;
    b_seg = {4{15'h7FFF}};
    b_zp  = {6'd61, 6'd46, 6'd50, 6'd60};
    b_iv  = 1'b1;
    tick();
    b_iv = 1'b0;
    tick();
    chk("ml_ov", 64'(b_ov), 64'd1);
    chk("ml_md", 64'(b_md),
        64'({15'h7FFF, 15'h7FFE, 15'h7FEF, 15'h3FFF}));
    chk("ml_mh", 64'(b_mh), 64'b0111);
    tick();

`ifdef SEG_MASK_STATS_EN
    chk("st_first", 64'(b_cnt), 64'd3);
    for (int k = 0; k < 5; k++) begin
      b_iv = 1'b1;
      tick();
      b_iv = 1'b0;
      tick();
      tick();
      if (k == 3) chk("st_15", 64'(b_cnt), 64'd15);
    end
    chk("st_sat", 64'(b_cnt), 64'd15);
    b_iv = 1'b1;
    tick();
    b_iv = 1'b0;
    tick();
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    chk("st_clr", 64'(b_cnt), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
